// File: rtl/ssd_scan_ctl_if.sv
// Digit inputs and segment/enable outputs of the seven-segment scan controller.
interface ssd_scan_ctl_if;
  logic [3:0] in0;
  logic [3:0] in1;
  logic [3:0] in2;
  logic [3:0] in3;
  logic       blank_en;
  logic [3:0] ssd_ctl;
  logic [7:0] display;
  logic       frame_tick;

  // Upstream side: supplies digits and reads back the display drive.
  modport master (
    output in0, in1, in2, in3, blank_en,
    input  ssd_ctl, display, frame_tick
  );

  // Scan controller side.
  modport slave (
    input  in0, in1, in2, in3, blank_en,
    output ssd_ctl, display, frame_tick
  );
endinterface

// File: rtl/ssd_scan_ctl.sv
// Four-digit common-anode scan controller: per-frame digit snapshot, hex
// decode, optional leading-zero blanking, registered active-low outputs.
module ssd_scan_ctl #(
  parameter int SCAN_DIV = 4
) (
  input  logic           clk_out,
  input  logic           rst_n,
  ssd_scan_ctl_if.slave  bus
);

  localparam logic [15:0] CNT_MAX = 16'(SCAN_DIV - 1);

  logic [15:0]      cnt_q, cnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [3:0][3:0]  snap_q, snap_d;
  logic [3:0]       ssd_ctl_q, ssd_ctl_d;
  logic [7:0]       display_q, display_d;
  logic             frame_tick_q, frame_tick_d;

  logic             wrap;
  logic             frame;
  logic [3:0]       blank_vec;
  logic [3:0]       cur_digit;

  // Active-low segments {a,b,c,d,e,f,g,dp}; dp is always off.
  function automatic logic [7:0] seg_decode(input logic [3:0] v);
    logic [7:0] s;
    case (v)
      4'h0: s = 8'h03;
      4'h1: s = 8'h9F;
      4'h2: s = 8'h25;
      4'h3: s = 8'h0D;
      4'h4: s = 8'h99;
      4'h5: s = 8'h49;
      4'h6: s = 8'h41;
      4'h7: s = 8'h1F;
      4'h8: s = 8'h01;
      4'h9: s = 8'h09;
      4'hA: s = 8'h11;
      4'hB: s = 8'hC1;
      4'hC: s = 8'h63;
      4'hD: s = 8'h85;
      4'hE: s = 8'h61;
      default: s = 8'h71;
    endcase
    return s;
  endfunction

  // Prescaler, digit select, frame snapshot and output drive for the next edge.
  always_comb begin
    wrap         = (cnt_q == CNT_MAX);
    frame        = wrap && (sel_q == 2'd3);
    cnt_d        = wrap ? 16'd0 : cnt_q + 16'd1;
    sel_d        = wrap ? sel_q + 2'd1 : sel_q;
    snap_d       = snap_q;
    frame_tick_d = frame;
    if (frame) begin
      snap_d = {bus.in3, bus.in2, bus.in1, bus.in0};
    end

    // Blanking looks only at the snapshot, so a mid-frame input change
    // cannot make a digit flicker on or off.
    blank_vec    = 4'b0000;
    blank_vec[3] = (snap_q[3] == 4'd0);
    blank_vec[2] = blank_vec[3] && (snap_q[2] == 4'd0);
    blank_vec[1] = blank_vec[2] && (snap_q[1] == 4'd0);
    if (!bus.blank_en) begin
      blank_vec = 4'b0000;
    end

    cur_digit = snap_q[sel_q];
    if (blank_vec[sel_q]) begin
      ssd_ctl_d = 4'b1111;
      display_d = 8'hFF;
    end else begin
      ssd_ctl_d = ~(4'b0001 << sel_q);
      display_d = seg_decode(cur_digit);
    end
  end

  // State and output registers; reset leaves the display dark.
  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= 16'd0;
      sel_q        <= 2'd0;
      snap_q       <= '0;
      ssd_ctl_q    <= 4'b1111;
      display_q    <= 8'hFF;
      frame_tick_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      snap_q       <= snap_d;
      ssd_ctl_q    <= ssd_ctl_d;
      display_q    <= display_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign bus.ssd_ctl    = ssd_ctl_q;
  assign bus.display    = display_q;
  assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_ssd_scan_ctl.sv
// Bench for ssd_scan_ctl: directed scenarios plus random input traffic,
// compared every edge against an edge-count based reference model.
module tb_ssd_scan_ctl;

  localparam int N = 4;

  logic clk_out = 1'b0;
  logic rst_n   = 1'b0;

  ssd_scan_ctl_if bus ();

  ssd_scan_ctl #(.SCAN_DIV(N)) dut (
    .clk_out (clk_out),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  always #5 clk_out = ~clk_out;

  int checks = 0;
  int errors = 0;
  int e      = 0;
  int msnap [4];

  logic [7:0] seg_tab [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                               8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

  task automatic set_in(input int a0, input int a1, input int a2, input int a3);
    bus.in0 = 4'(a0);
    bus.in1 = 4'(a1);
    bus.in2 = 4'(a2);
    bus.in3 = 4'(a3);
  endtask

  task automatic model_reset();
    e = 0;
    for (int i = 0; i < 4; i++) msnap[i] = 0;
  endtask

  // One clock edge: capture what the DUT sees, clock, then compare.
  task automatic step();
    int pin [4];
    int pblank, sel, lz, exp_tick;
    logic [3:0] exp_ctl;
    logic [7:0] exp_disp;
    pin[0] = int'(bus.in0);
    pin[1] = int'(bus.in1);
    pin[2] = int'(bus.in2);
    pin[3] = int'(bus.in3);
    pblank = int'(bus.blank_en);
    @(posedge clk_out);
    e++;
    #1;
    sel = ((e - 1) / N) % 4;
    lz = 0;
    for (int k = 3; k >= 1; k--) begin
      if (msnap[k] != 0) break;
      lz++;
    end
    if (pblank != 0 && sel > 0 && sel >= 4 - lz) begin
      exp_ctl  = 4'hF;
      exp_disp = 8'hFF;
    end else begin
      exp_ctl  = 4'(15 - (1 << sel));
      exp_disp = seg_tab[msnap[sel]];
    end
    exp_tick = (e % (4 * N) == 0) ? 1 : 0;
    if (exp_tick != 0) begin
      for (int i = 0; i < 4; i++) msnap[i] = pin[i];
    end
    checks++;
    assert (bus.ssd_ctl === exp_ctl) else begin
      errors++;
      $error("FAIL ssd_ctl e=%0d got %b exp %b", e, bus.ssd_ctl, exp_ctl);
    end
    checks++;
    assert (bus.display === exp_disp) else begin
      errors++;
      $error("FAIL display e=%0d got %h exp %h", e, bus.display, exp_disp);
    end
    checks++;
    assert (bus.frame_tick === 1'(exp_tick)) else begin
      errors++;
      $error("FAIL frame_tick e=%0d got %b exp %0d", e, bus.frame_tick, exp_tick);
    end
    checks++;
    assert (bus.display[0] === 1'b1) else begin
      errors++;
      $error("FAIL dp e=%0d got %b exp 1", e, bus.display[0]);
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    set_in(1, 0, 1, 0);
    bus.blank_en = 1'b0;
    #23;
    checks++;
    assert (bus.ssd_ctl === 4'b1111 && bus.display === 8'hFF && bus.frame_tick === 1'b0) else begin
      errors++;
      $error("FAIL reset_state got %b/%h/%b exp 1111/ff/0", bus.ssd_ctl, bus.display, bus.frame_tick);
    end
    @(negedge clk_out);
    rst_n = 1'b1;
    model_reset();

    // Scenario 1: release, inputs 1,0,1,0, through the second frame start.
    steps(20);
    // Mid-frame change at edge 22 must not show until the following frame.
    steps(1);
    set_in(0, 1, 0, 1);
    steps(16);

    // Steady 3,2,1,0 over two frames.
    set_in(3, 2, 1, 0);
    steps(32);

    // Leading-zero blanking then live release of blank_en.
    set_in(5, 0, 0, 0);
    bus.blank_en = 1'b1;
    steps(32);
    bus.blank_en = 1'b0;
    steps(8);
    bus.blank_en = 1'b1;
    steps(8);
    bus.blank_en = 1'b0;

    // All sixteen codes on in0, one per frame.
    for (int v = 0; v < 16; v++) begin
      set_in(v, v ^ 5, 15 - v, v & 3);
      steps(4 * N);
    end

    // Async reset mid-digit, then the first scenario again.
    steps(6);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    assert (bus.ssd_ctl === 4'b1111 && bus.display === 8'hFF && bus.frame_tick === 1'b0) else begin
      errors++;
      $error("FAIL async_reset got %b/%h/%b exp 1111/ff/0", bus.ssd_ctl, bus.display, bus.frame_tick);
    end
    set_in(1, 0, 1, 0);
    bus.blank_en = 1'b0;
    @(negedge clk_out);
    rst_n = 1'b1;
    model_reset();
    steps(20);

    // Random traffic, including changes on frame-boundary edges.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        set_in(int'($urandom_range(0, 15)), int'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(0, 15)),
               int'($urandom_range(0, 1) == 0 ? 0 : $urandom_range(0, 15)),
               int'($urandom_range(0, 1) == 0 ? 0 : $urandom_range(0, 15)));
      end
      if ($urandom_range(0, 15) == 0) bus.blank_en = ~bus.blank_en;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
